seg_scan_driver: RTL and testbench
==================================

// Module: seg_scan_driver
// PURPOSE
//  Consumes the 20-bit display word produced by the top-level manager
//    (4 digits x 5-bit char code; digit 0 = disp[4:0], rightmost).
//  Drives a 4-digit, common-anode, multiplexed 7-segment display.
//  Latches disp once per frame so that mid-frame changes never tear.
//  Inserts a dead (blanking) time between digit slots to suppress ghosting.
// PARAMETERS
//  DIGIT_TICKS   50000  clk cycles per digit slot (incl. dead time); must be >= 2
//  DEAD_TICKS    500    cycles at slot start with all anodes off; must be < DIGIT_TICKS
//  BLINK_FRAMES  128    frames per blink half-period (SEG_BLINK_EN only)
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   asynchronous reset, active-low
//  disp         in   20  4 x 5-bit char codes from manager
//  blink_mask   in   4   per-digit blink enable; port exists only with SEG_BLINK_EN
//  an           out  4   digit anode enables, active-low, one-hot-low or all high
//  seg          out  7   segments {g,f,e,d,c,b,a}, active-low
//  frame_start  out  1   one-cycle pulse when disp is latched (verification hook)
// BEHAVIOUR
//  Reset (async assert, sync release):
//    an=4'b1111, seg=7'h7F, frame_start=0, tick=0, idx=0, frame reg = all CH_BLANK.
//  tick counts 0..DIGIT_TICKS-1 and wraps; on wrap idx advances 0->1->2->3->0.
//  Frame latch: on the cycle tick wraps with idx==3, frame<=disp, frame_start=1 next cycle.
//  Outputs registered; for tick < DEAD_TICKS: an=4'b1111, seg=7'h7F.
//  Otherwise an[idx]=0 (others 1) and seg=decode(frame[idx]).
//  Latency: disp change stable before a frame latch shows on digit 0 at
//    frame_start + DEAD_TICKS + 1 cycles.
//  Char decode (5-bit):
//    0x00-0x0F  hex 0-F
//    0x10 blank, 0x11 H, 0x12 L, 0x13 P, 0x14 '-', 0x15 U, 0x16 r, 0x17 n
//    0x18-0x1F  blank
//  disp changing on the same cycle as the latch: the new value is captured (no metastability; same clk).
//  Reset mid-slot: outputs go dark immediately; scanning restarts at idx 0 with a dead slot.
//  At most one anode low in any cycle; idx/tick transitions never glitch outputs
//    (outputs come from flops only).
// CONFIGURATION
//  SEG_BLINK_EN defined:
//    blink_mask port present; frame counter (0..BLINK_FRAMES-1) toggles blink_ph on wrap.
//    While blink_ph=1, digits with blink_mask[idx]=1 output seg=7'h7F (anode still scanned).
//    blink_mask is sampled at the frame latch with disp; blink_ph resets to 0.
//  SEG_BLINK_EN undefined:
//    no blink_mask port, no frame counter; all digits always shown.
// STRUCTURE
//  Package seg_pkg:
//    SEG_DIGITS=4, CHAR_W=5, CH_BLANK=5'h10, named char codes 0x11-0x17,
//    SEG_OFF=7'h7F, AN_OFF=4'hF.
//  Sub-module seg_char_decode: combinational 5-bit code -> 7-bit active-low pattern.
//  Top: tick/idx counters, frame register, output flops, optional blink counter.
// TESTING (bench with DIGIT_TICKS=20, DEAD_TICKS=4, BLINK_FRAMES=2)
//  1 Reset:
//    rst_n=0 mid-scan -> an=4'hF, seg=7'h7F same cycle.
//    After release, first frame shows blank on all digits.
//  2 Scan:
//    disp={5'h3,5'h2,5'h1,5'h0} -> anodes E,D,B,7 in order, 16 lit cycles each.
//    seg=40,79,24,30 respectively.
//  3 Dead time:
//    first 4 cycles of every slot an=4'hF, seg=7'h7F.
//    Never more than one anode low.
//  4 Tear-free:
//    change disp mid-frame to {5'h11,5'h12,5'h13,5'h14} -> old value held until frame_start.
//    Then H,L,P,- appear (seg 09,47,0C,3F).
//  5 Codes:
//    0x10 and 0x1F -> seg=7'h7F.
//    0x0A -> 7'h08, 0x0F -> 7'h0E.
//  6 SEG_BLINK_EN, blink_mask=4'b0001 -> digit 0 dark for 2 frames, lit for 2, repeating.
//    Other digits unaffected.

Source files
------------

// File: rtl/seg_pkg.sv
// seg_pkg: shared widths, char codes and idle patterns for the
// multiplexed 7-segment scan driver.
package seg_pkg;

  localparam int SEG_DIGITS = 4;
  localparam int CHAR_W     = 5;

  localparam logic [CHAR_W-1:0] CH_BLANK = 5'h10;
  localparam logic [CHAR_W-1:0] CH_H     = 5'h11;
  localparam logic [CHAR_W-1:0] CH_L     = 5'h12;
  localparam logic [CHAR_W-1:0] CH_P     = 5'h13;
  localparam logic [CHAR_W-1:0] CH_DASH  = 5'h14;
  localparam logic [CHAR_W-1:0] CH_U     = 5'h15;
  localparam logic [CHAR_W-1:0] CH_R     = 5'h16;
  localparam logic [CHAR_W-1:0] CH_N     = 5'h17;

  localparam logic [6:0]            SEG_OFF = 7'h7F;
  localparam logic [SEG_DIGITS-1:0] AN_OFF  = 4'hF;

endpackage

// File: rtl/seg_char_decode.sv
// seg_char_decode: 5-bit char code to active-low {g,f,e,d,c,b,a}.
// Codes 0x00-0x0F are hex digits; unknown codes are blank.
module seg_char_decode
  import seg_pkg::*;
(
  input  logic [CHAR_W-1:0] code,
  output logic [6:0]        pat
);

  always_comb begin
    pat = SEG_OFF;
    unique case (code)
      5'h00:   pat = 7'h40;
      5'h01:   pat = 7'h79;
      5'h02:   pat = 7'h24;
      5'h03:   pat = 7'h30;
      5'h04:   pat = 7'h19;
      5'h05:   pat = 7'h12;
      5'h06:   pat = 7'h02;
      5'h07:   pat = 7'h78;
      5'h08:   pat = 7'h00;
      5'h09:   pat = 7'h10;
      5'h0A:   pat = 7'h08;
      5'h0B:   pat = 7'h03;
      5'h0C:   pat = 7'h46;
      5'h0D:   pat = 7'h21;
      5'h0E:   pat = 7'h06;
      5'h0F:   pat = 7'h0E;
      CH_H:    pat = 7'h09;
      CH_L:    pat = 7'h47;
      CH_P:    pat = 7'h0C;
      CH_DASH: pat = 7'h3F;
      CH_U:    pat = 7'h41;
      CH_R:    pat = 7'h2F;
      CH_N:    pat = 7'h2B;
      default: pat = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: 4-digit common-anode scan with frame latch and dead time.
// Optional per-digit blinking is enabled with `define SEG_BLINK_EN.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIGIT_TICKS  = 50000,
  parameter int DEAD_TICKS   = 500,
  parameter int BLINK_FRAMES = 128
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [SEG_DIGITS*CHAR_W-1:0] disp,
`ifdef SEG_BLINK_EN
  input  logic [SEG_DIGITS-1:0]        blink_mask,
`endif
  output logic [SEG_DIGITS-1:0]        an,
  output logic [6:0]                   seg,
  output logic                         frame_start
);

  localparam int TW = $clog2(DIGIT_TICKS);
  localparam int IW = $clog2(SEG_DIGITS);

  if (DIGIT_TICKS < 2) begin : g_bad_ticks
    $error("DIGIT_TICKS must be >= 2");
  end
  if (DEAD_TICKS >= DIGIT_TICKS) begin : g_bad_dead
    $error("DEAD_TICKS must be < DIGIT_TICKS");
  end
  if (BLINK_FRAMES < 1) begin : g_bad_blink
    $error("BLINK_FRAMES must be >= 1");
  end

  logic [TW-1:0]                tick;
  logic [IW-1:0]                idx;
  logic [SEG_DIGITS*CHAR_W-1:0] frame;
  logic                         wrap;
  logic                         latch;
  logic                         dead;
  logic                         dim;
  logic [CHAR_W-1:0]            code;
  logic [6:0]                   pat;
  logic [SEG_DIGITS-1:0]        an_d;
  logic [6:0]                   seg_d;

  assign wrap  = tick == TW'(DIGIT_TICKS - 1);
  assign latch = wrap && (idx == IW'(SEG_DIGITS - 1));
  assign dead  = tick < TW'(DEAD_TICKS);
  assign code  = frame[idx*CHAR_W +: CHAR_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick        <= '0;
      idx         <= '0;
      frame       <= {SEG_DIGITS{CH_BLANK}};
      frame_start <= 1'b0;
    end else begin
      frame_start <= latch;
      if (wrap) begin
        tick <= '0;
        idx  <= idx + 1'b1;
      end else begin
        tick <= tick + 1'b1;
      end
      if (latch) frame <= disp;
    end
  end

`ifdef SEG_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FW-1:0]         fcnt;
  logic                  blink_ph;
  logic [SEG_DIGITS-1:0] mask_q;

  // Mask travels with the frame so blinking never tears either.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt     <= '0;
      blink_ph <= 1'b0;
      mask_q   <= '0;
    end else if (latch) begin
      mask_q <= blink_mask;
      if (fcnt == FW'(BLINK_FRAMES - 1)) begin
        fcnt     <= '0;
        blink_ph <= ~blink_ph;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  assign dim = blink_ph & mask_q[idx];
`else
  assign dim = 1'b0;
`endif

  seg_char_decode u_dec (
    .code (code),
    .pat  (pat)
  );

  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    if (!dead) begin
      an_d[idx] = 1'b0;
      if (!dim) seg_d = pat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
    end else begin
      an  <= an_d;
      seg <= seg_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: scoreboard bench for the 7-segment scan driver
// with DIGIT_TICKS=20, DEAD_TICKS=4, BLINK_FRAMES=2.
module tb_seg_scan_driver;

  localparam int DT  = 20;
  localparam int DD  = 4;
  localparam int BF  = 2;
  localparam int LIT = DT - DD;
`ifdef SEG_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [19:0] disp;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        frame_start;
`ifdef SEG_BLINK_EN
  logic [3:0]  blink_mask;
`endif

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  seg_scan_driver #(
    .DIGIT_TICKS  (DT),
    .DEAD_TICKS   (DD),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .disp        (disp),
`ifdef SEG_BLINK_EN
    .blink_mask  (blink_mask),
`endif
    .an          (an),
    .seg         (seg),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3);
    q.push_back('{an: 4'hE, seg: s0});
    q.push_back('{an: 4'hD, seg: s1});
    q.push_back('{an: 4'hB, seg: s2});
    q.push_back('{an: 4'h7, seg: s3});
  endtask

  task automatic wait_fs();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 200);
    chk("fs_timeout", {31'd0, frame_start}, 1);
  endtask

  // Monitor: every lit run of one anode is one scoreboard entry.
  logic [3:0] prev_an, run_an;
  logic [6:0] run_seg;
  logic       prev_fs, first;
  int         run_len, dead_len;

  initial begin
    exp_t e;
    prev_an  = 4'hF;
    prev_fs  = 1'b0;
    first    = 1'b1;
    run_len  = 0;
    dead_len = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_an  = 4'hF;
        prev_fs  = 1'b0;
        first    = 1'b1;
        run_len  = 0;
        dead_len = 0;
      end else begin
        chk("onehot_low", {31'd0, $countones(~an) <= 1}, 1);
        if (an == 4'hF) chk("dead_seg", {25'd0, seg}, 32'h7F);
        if (frame_start) begin
          chk("fs_an", {28'd0, an}, 32'h7);
          chk("fs_width", {31'd0, prev_fs}, 0);
        end
        if (prev_an != 4'hF && an != prev_an) begin
          chk("sb_nonempty", {31'd0, q.size() > 0}, 1);
          if (q.size() > 0) begin
            e = q.pop_front();
            chk("slot_an", {28'd0, run_an}, {28'd0, e.an});
            chk("slot_seg", {25'd0, run_seg}, {25'd0, e.seg});
            chk("slot_len", run_len, LIT);
          end
        end
        if (an != 4'hF && an != prev_an) begin
          if (!first) chk("dead_len", dead_len, DD);
          first    = 1'b0;
          run_an   = an;
          run_seg  = seg;
          run_len  = 1;
          dead_len = 0;
        end else if (an != 4'hF) begin
          run_len++;
          chk("seg_stable", {25'd0, seg}, {25'd0, run_seg});
        end else begin
          dead_len++;
        end
        prev_an = an;
        prev_fs = frame_start;
      end
    end
  end

  initial begin
    int n;
    disp = {5'h03, 5'h02, 5'h01, 5'h00};
`ifdef SEG_BLINK_EN
    blink_mask = 4'b0001;
`endif
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("pre_rst_an", {28'd0, an}, 32'hE);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_an", {28'd0, an}, 32'hF);
    chk("rst_seg", {25'd0, seg}, 32'h7F);
    chk("rst_fs", {31'd0, frame_start}, 0);
    repeat (2) @(posedge clk);
    push_frame(7'h7F, 7'h7F, 7'h7F, 7'h7F);
    push_frame(7'h40, 7'h79, 7'h24, 7'h30);
    #1 rst_n = 1'b1;

    wait_fs();
    repeat (30) @(posedge clk);
    #1 disp = {5'h11, 5'h12, 5'h13, 5'h14};
    push_frame(BLINK ? 7'h7F : 7'h3F, 7'h0C, 7'h47, 7'h09);

    // New value lands on the very edge that latches the frame.
    wait_fs();
    repeat (DT*4 - 1) @(posedge clk);
    #1 disp = {5'h0F, 5'h1F, 5'h10, 5'h0A};
    push_frame(BLINK ? 7'h7F : 7'h08, 7'h7F, 7'h7F, 7'h0E);
    push_frame(7'h08, 7'h7F, 7'h7F, 7'h0E);

    n = 0;
    while (q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q.size(), 0);
    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
